sdp_ram_bec: RTL
================

# sdp_ram_bec

Parametrised single-clock simple dual-port RAM. It is the next generation of the video-path block RAM wrapper, adding:
- per-byte write enables
- selectable read latency
- defined read-during-write behaviour
- a built-in clear sequencer that fills the array with a constant after reset or on request

It sits between the line/frame buffering logic and the memory primitives. Clients must gate their accesses on `busy`.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, address bits; depth = 2**ADDR_WIDTH (legal 4..12).
- `DATA_WIDTH`, 8, word width; must be a multiple of BYTE_WIDTH (legal 8..256).
- `BYTE_WIDTH`, 8, bits per write-enable lane; BE_WIDTH = DATA_WIDTH/BYTE_WIDTH.
- `OUT_REG`, 0, 1 adds an output register stage (read latency 2 instead of 1).
- `RDW_MODE`, "NEW", same-address read-during-write returns "NEW" (merged write data) or "OLD" (prior contents).
- `CLR_ON_RST`, 1, 1 runs a full clear sequence after every reset.
- `CLR_VALUE`, 0, DATA_WIDTH-bit fill value used by the clear sequence.

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `rst`, in, 1, reset, synchronous, active-high.
- `wr_en`, in, 1, write strobe.
- `wr_addr`, in, ADDR_WIDTH, write address.
- `wr_data`, in, DATA_WIDTH, write data.
- `wr_be`, in, BE_WIDTH, byte enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- `rd_en`, in, 1, read strobe.
- `rd_addr`, in, ADDR_WIDTH, read address.
- `rd_data`, out, DATA_WIDTH, read data.
- `rd_valid`, out, 1, one-cycle pulse marking `rd_data` as valid.
- `clr_req`, in, 1, request a clear sequence (sampled in IDLE only).
- `busy`, out, 1, clear sequence in progress; user accesses are ignored.

## Operation
- FSM has two states: IDLE and CLEAR.
- Reset:
  - state <= (CLR_ON_RST ? CLEAR : IDLE)
  - clr_addr <= 0
  - `rd_data` <= 0, `rd_valid` <= 0, pipeline valid bits <= 0
  - Array contents are not touched by `rst` itself.
- CLEAR:
  - Each cycle writes CLR_VALUE to all lanes at clr_addr, then clr_addr += 1.
  - On the cycle clr_addr == 2**ADDR_WIDTH-1, the final write occurs and state -> IDLE.
  - A CLEAR pass lasts exactly 2**ADDR_WIDTH cycles.
  - `wr_en`, `rd_en` and `clr_req` are ignored; no `rd_valid` is generated.
- IDLE:
  - `clr_req` high -> CLEAR with clr_addr <= 0. Any user write or read in that same cycle is still performed.
- Write: `wr_en` high updates only the lanes whose `wr_be` bit is set. `wr_be` = 0 is a no-op.
- Read: `rd_en` high launches a read of `rd_addr`.
- `rd_data` holds its last value when no read completes.
- Same-address read and write in one cycle:
  - RDW_MODE "NEW": read returns the word after the byte-masked merge.
  - RDW_MODE "OLD": read returns the contents before the write.
- Different addresses in the same cycle are fully independent.
- `busy` = (state == CLEAR), decoded from the registered state.

## Timing
- Read latency:
  - OUT_REG=0: `rd_data`/`rd_valid` appear 1 cycle after the `rd_en` edge.
  - OUT_REG=1: they appear 2 cycles after.
- Reads are fully pipelined: one read per cycle, `rd_valid` back-to-back.
- Writes are visible to a read launched on the following cycle (and the same cycle under "NEW").
- `busy` reset value = CLR_ON_RST. It is high while `rst` is high if CLR_ON_RST=1, and falls on the edge after the last clear write.
- First accepted user access after reset (CLR_ON_RST=1) is on cycle 2**ADDR_WIDTH after `rst` deasserts.
- Reads in flight when a clear starts still complete with their `rd_valid`, returning pre-clear data.
- `rst` asserted mid-clear aborts the pass; the sequence restarts at address 0 once `rst` is released.
- `rst` asserted mid-read flushes the pipeline; no `rd_valid` follows.
- clr_addr wraps naturally. There is no terminal-count overflow because the FSM exits on all-ones.

## Test plan
- Reset then clear:
  - Stimulus: CLR_ON_RST=1, CLR_VALUE=8'hA5, ADDR_WIDTH=10; `rst` held 20 cycles, then released.
  - Required: `busy` high for exactly 1024 cycles after release.
  - Required: reading all 1024 addresses afterwards returns 8'hA5, `rd_valid` 1 cycle after each `rd_en` (OUT_REG=0).
- Byte-enable merge:
  - Stimulus: DATA_WIDTH=32; write 32'h11223344 be=4'hF to addr 5, then 32'hAABBCCDD be=4'b0101.
  - Required: read of addr 5 returns 32'h11BB33DD.
- Read-during-write:
  - Stimulus: addr 7 holds 8'h00; same cycle wr 8'hFF, rd addr 7.
  - Required: RDW_MODE "NEW" returns 8'hFF, "OLD" returns 8'h00; next-cycle read returns 8'hFF in both.
- Pipelined reads with OUT_REG=1:
  - Stimulus: rd_en held for 8 cycles over addresses 0..7 containing ~addr.
  - Required: `rd_valid` high for 8 consecutive cycles starting 2 cycles later, data in order.
- Clear request and ignored accesses:
  - Stimulus: `clr_req` pulse in IDLE, then `wr_en` to addr 3 with 8'h5A during busy.
  - Required: write dropped, addr 3 reads CLR_VALUE, no `rd_valid` for reads issued while busy.
- Reset mid-clear:
  - Stimulus: assert `rst` at clear cycle 300 for 2 cycles.
  - Required: `busy` stays high; a full 1024-cycle pass runs from address 0 after release.

Source files
------------

// File: rtl/sdp_ram_bec.sv
// -----------------------------------------------------------------------------
// sdp_ram_bec
//   Single-clock simple dual-port RAM for the video line/frame buffers.
//   One write port with per-byte enables, one pipelined read port with a
//   selectable read latency of 1 or 2 cycles, defined same-address
//   read-during-write behaviour, and a clear sequencer that fills the whole
//   array with CLR_VALUE after reset and/or on request.
//
// Ports
//   clk        in   single clock, everything on the rising edge
//   rst        in   synchronous active-high reset (array contents untouched)
//   wr_en      in   write strobe
//   wr_addr    in   write address
//   wr_data    in   write data
//   wr_be      in   byte enables, lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH]
//   rd_en      in   read strobe
//   rd_addr    in   read address
//   rd_data    out  read data, held between completed reads
//   rd_valid   out  one-cycle pulse, rd_data carries the result of a read
//   clr_req    in   start a clear pass (only looked at while idle)
//   busy       out  clear pass in progress, user accesses are dropped
//   dbg_state  out  raw FSM state (0 = IDLE, 1 = CLEAR) for checkers
//
// Transfer contract: there is no back-pressure. A write or read is accepted
// on every rising edge where its strobe is high, busy is low and rst is low;
// otherwise it is silently dropped. Every accepted read produces exactly one
// rd_valid pulse, in order, 1 (OUT_REG=0) or 2 (OUT_REG=1) edges later,
// unless rst arrives in between, which discards everything in flight.
// -----------------------------------------------------------------------------
module sdp_ram_bec #(
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    BYTE_WIDTH = 8,
   parameter int                    OUT_REG    = 0,
   parameter                        RDW_MODE   = "NEW",
   parameter int                    CLR_ON_RST = 1,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
   input  logic                             rd_en,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_valid,
   input  logic                             clr_req,
   output logic                             busy,
   output logic                             dbg_state
);

   localparam int BE_WIDTH = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH    = 1 << ADDR_WIDTH;
   localparam bit RDW_NEW  = (RDW_MODE == "NEW");

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_clr_addr;

   logic                  w_idle;
   logic                  w_clearing;
   logic                  w_wr_fire;
   logic                  w_rd_fire;
   logic                  w_rdw_hit;
   logic [DATA_WIDTH-1:0] w_rd_old;
   logic [DATA_WIDTH-1:0] w_rd_word;

   // rst blocks every array write so that reset alone never alters contents.
   assign w_idle     = !rst && (r_state == ST_IDLE);
   assign w_clearing = !rst && (r_state == ST_CLEAR);
   assign w_wr_fire  = w_idle && wr_en;
   assign w_rd_fire  = w_idle && rd_en;
   assign w_rdw_hit  = RDW_NEW && w_wr_fire && (wr_addr == rd_addr);

   assign busy      = (r_state == ST_CLEAR);
   assign dbg_state = r_state;

   // -------------------------------------------------------------------------
   // Clear sequencer. The pass ends on the all-ones address, so the address
   // counter never needs a terminal-count bit.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
         r_clr_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (clr_req) begin
                  r_state    <= ST_CLEAR;
                  r_clr_addr <= '0;
               end
            end
            ST_CLEAR: begin
               r_clr_addr <= r_clr_addr + 1'b1;
               if (r_clr_addr == '1) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Storage: one array per byte lane so each lane has a plain
   // single-write-port pattern. The clear pass owns every lane while active.
   // -------------------------------------------------------------------------
   for (genvar g = 0; g < BE_WIDTH; g++) begin : g_lane
      logic [BYTE_WIDTH-1:0] r_lane [DEPTH];

      always_ff @(posedge clk) begin
         if (w_clearing) begin
            r_lane[r_clr_addr] <= CLR_VALUE[g*BYTE_WIDTH +: BYTE_WIDTH];
         end else if (w_wr_fire && wr_be[g]) begin
            r_lane[wr_addr] <= wr_data[g*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end

      assign w_rd_old[g*BYTE_WIDTH +: BYTE_WIDTH] = r_lane[rd_addr];

      // "NEW" mode forwards only the lanes being written this cycle.
      assign w_rd_word[g*BYTE_WIDTH +: BYTE_WIDTH] =
         (w_rdw_hit && wr_be[g]) ? wr_data[g*BYTE_WIDTH +: BYTE_WIDTH]
                                 : w_rd_old[g*BYTE_WIDTH +: BYTE_WIDTH];
   end

   // -------------------------------------------------------------------------
   // Read pipeline. Stages advance regardless of the FSM, so reads launched
   // just before a clear starts still deliver their pre-clear data.
   // -------------------------------------------------------------------------
   if (OUT_REG != 0) begin : g_out_reg
      logic                  r_p1_valid;
      logic [DATA_WIDTH-1:0] r_p1_data;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_data  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
         end else begin
            r_p1_valid <= w_rd_fire;
            if (w_rd_fire) begin
               r_p1_data <= w_rd_word;
            end
            rd_valid <= r_p1_valid;
            if (r_p1_valid) begin
               rd_data <= r_p1_data;
            end
         end
      end
   end else begin : g_no_out_reg
      always_ff @(posedge clk) begin
         if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
         end else begin
            rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
               rd_data <= w_rd_word;
            end
         end
      end
   end

endmodule
